// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences idle/serve/play/point/game-over, keeps scores
// and issues one-cycle position-load, serve and physics-step enables each frame.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4,
    parameter int SERVE_DELAY = 60,
    parameter int TICK_DIV    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [3:0]         btn_n,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               load_pos,
    output logic               serve,
    output logic               serve_dir,
    output logic               step_en,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);
    localparam int SC_W = $clog2(SERVE_DELAY + 1);
    localparam int TK_W = $clog2(TICK_DIV + 1);
    localparam logic [SC_W-1:0]    SERVE_INIT = SC_W'(SERVE_DELAY);
    localparam logic [TK_W-1:0]    TICK_LAST  = TK_W'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    state_t              st_q, st_d;
    logic [3:0]          sync1, sync2;
    logic                any_press;
    logic [SC_W-1:0]     serve_cnt_q, serve_cnt_d;
    logic [TK_W-1:0]     tick_q, tick_d;
    logic [SCORE_W-1:0]  p1_d, p2_d;
    logic                dir_d, winner_d, armed_q, armed_d;
    logic                load_d, serve_d, step_d;

    assign any_press = |(~sync2);
    assign state     = st_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            sync1       <= 4'hF;
            sync2       <= 4'hF;
            serve_cnt_q <= '0;
            tick_q      <= '0;
            score_p1    <= '0;
            score_p2    <= '0;
            serve_dir   <= 1'b1;
            winner      <= 1'b0;
            armed_q     <= 1'b0;
            load_pos    <= 1'b0;
            serve       <= 1'b0;
            step_en     <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            st_q        <= st_d;
            sync1       <= btn_n;
            sync2       <= sync1;
            serve_cnt_q <= serve_cnt_d;
            tick_q      <= tick_d;
            score_p1    <= p1_d;
            score_p2    <= p2_d;
            serve_dir   <= dir_d;
            winner      <= winner_d;
            armed_q     <= armed_d;
            load_pos    <= load_d;
            serve       <= serve_d;
            step_en     <= step_d;
            game_over   <= (st_d == GAME_OVER);
        end
    end

    always_comb begin
        st_d        = st_q;
        serve_cnt_d = serve_cnt_q;
        tick_d      = tick_q;
        p1_d        = score_p1;
        p2_d        = score_p2;
        dir_d       = serve_dir;
        winner_d    = winner;
        armed_d     = armed_q;
        load_d      = 1'b0;
        serve_d     = 1'b0;
        step_d      = 1'b0;
        unique case (st_q)
            IDLE: if (any_press) begin
                st_d        = SERVE_WAIT;
                load_d      = 1'b1;
                serve_cnt_d = SERVE_INIT;
            end
            SERVE_WAIT: if (frame_start) begin
                serve_cnt_d = serve_cnt_q - 1'b1;
                if (serve_cnt_q == SC_W'(1)) begin
                    st_d    = PLAY;
                    serve_d = 1'b1;
                    tick_d  = '0;
                end
            end
            PLAY: begin
                // A miss wins over a coincident frame, so no step is issued on a scoring cycle.
                if (miss_left || miss_right) begin
                    st_d = POINT;
                    if (miss_left && !miss_right) begin
                        dir_d = 1'b0;
                        if (score_p2 != WIN) p2_d = score_p2 + 1'b1;
                    end else if (miss_right && !miss_left) begin
                        dir_d = 1'b1;
                        if (score_p1 != WIN) p1_d = score_p1 + 1'b1;
                    end
                end else if (frame_start) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        step_d = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            POINT: begin
                armed_d = 1'b0;
                if (score_p1 == WIN) begin
                    st_d     = GAME_OVER;
                    winner_d = 1'b0;
                end else if (score_p2 == WIN) begin
                    st_d     = GAME_OVER;
                    winner_d = 1'b1;
                end else begin
                    st_d        = SERVE_WAIT;
                    load_d      = 1'b1;
                    serve_cnt_d = SERVE_INIT;
                end
            end
            GAME_OVER: begin
                // Restart needs a full release first so a held button cannot skip the end screen.
                if (armed_q && any_press) begin
                    st_d        = SERVE_WAIT;
                    armed_d     = 1'b0;
                    p1_d        = '0;
                    p2_d        = '0;
                    load_d      = 1'b1;
                    serve_cnt_d = SERVE_INIT;
                end else if (!any_press) begin
                    armed_d = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed and randomized checks of pong_game_ctrl against a per-cycle game model.
module tb_pong_game_ctrl;
    localparam int W  = 2;
    localparam int SD = 3;
    localparam int TD = 2;

    logic       clk = 0, rst = 1, frame_start = 0, miss_left = 0, miss_right = 0;
    logic [3:0] btn_n = 4'hF;
    logic       load_pos, serve, serve_dir, step_en, game_over, winner;
    logic [3:0] score_p1, score_p2;
    logic [2:0] state;

    int checks = 0, errors = 0;
    int cnt_a, cnt_b;

    // model of the game, in plain integers
    int   m_phase, m_s1, m_s2, m_left, m_tick;
    bit   m_dir, m_win, m_armed, m_load, m_serve, m_step;
    bit [3:0] m_b1, m_b2;

    pong_game_ctrl #(.WIN_SCORE(W), .SCORE_W(4), .SERVE_DELAY(SD), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .btn_n(btn_n),
        .miss_left(miss_left), .miss_right(miss_right), .load_pos(load_pos),
        .serve(serve), .serve_dir(serve_dir), .step_en(step_en),
        .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over),
        .winner(winner), .state(state));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit anyp;
        anyp    = (m_b2 != 4'hF);
        m_load  = 0; m_serve = 0; m_step = 0;
        if (rst) begin
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_left = 0; m_tick = 0;
            m_dir = 1; m_win = 0; m_armed = 0; m_b1 = 4'hF; m_b2 = 4'hF;
            return;
        end
        m_b2 = m_b1;
        m_b1 = btn_n;
        case (m_phase)
            0: if (anyp) begin m_phase = 1; m_load = 1; m_left = SD; end
            1: if (frame_start) begin
                if (m_left == 1) begin m_phase = 2; m_serve = 1; m_tick = 0; end
                m_left--;
            end
            2: if (miss_left || miss_right) begin
                m_phase = 3;
                if (miss_left && !miss_right) begin m_dir = 0; if (m_s2 < W) m_s2++; end
                if (miss_right && !miss_left) begin m_dir = 1; if (m_s1 < W) m_s1++; end
            end else if (frame_start) begin
                m_tick++;
                if (m_tick == TD) begin m_tick = 0; m_step = 1; end
            end
            3: begin
                m_armed = 0;
                if (m_s1 == W) begin m_phase = 4; m_win = 0; end
                else if (m_s2 == W) begin m_phase = 4; m_win = 1; end
                else begin m_phase = 1; m_load = 1; m_left = SD; end
            end
            default: if (m_armed && anyp) begin
                m_phase = 1; m_armed = 0; m_s1 = 0; m_s2 = 0; m_load = 1; m_left = SD;
            end else if (!anyp) m_armed = 1;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state), 32'(m_phase));
        chk("scores", {score_p1, score_p2}, {4'(m_s1), 4'(m_s2)});
        chk("pulses", {load_pos, serve, step_en}, {m_load, m_serve, m_step});
        chk("flags", {serve_dir, game_over, winner}, {m_dir, m_phase == 4, (m_phase == 4) ? m_win : winner});
        if (m_phase == 4) chk("winner", 32'(winner), 32'(m_win));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_frame();
        frame_start = 1; tick(); frame_start = 0;
    endtask

    task automatic serve_ball();
        for (int i = 0; i < SD; i++) begin pulse_frame(); idle(2); end
    endtask

    initial begin
        rst = 1; idle(2); rst = 0;
        idle(5);
        chk("idle_hold", 32'(state), 32'd0);

        // press starts the game with a single load_pos
        btn_n = 4'hE; cnt_a = 0;
        for (int i = 0; i < 4; i++) begin tick(); cnt_a += int'(load_pos); end
        btn_n = 4'hF;
        for (int i = 0; i < 3; i++) begin tick(); cnt_a += int'(load_pos); end
        chk("load_once", 32'(cnt_a), 32'd1);
        for (int i = 0; i < SD; i++) begin
            pulse_frame();
            chk("serve_pulse", 32'(serve), (i == SD - 1) ? 32'd1 : 32'd0);
            tick();
            chk("serve_width", 32'(serve), 32'd0);
        end
        chk("in_play", 32'(state), 32'd2);

        // step every second frame
        cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            pulse_frame();
            chk("step_phase", 32'(step_en), (i % 2 == 1) ? 32'd1 : 32'd0);
            cnt_b += int'(step_en);
            idle(2);
        end
        chk("step_count", 32'(cnt_b), 32'd3);

        miss_right = 1; tick(); miss_right = 0;
        chk("p1_point", {28'd0, state, score_p1}, {28'd0, 3'd3, 4'd1});
        chk("dir_right", 32'(serve_dir), 32'd1);
        tick();
        chk("to_serve", {state, load_pos}, {3'd1, 1'b1});

        serve_ball();
        miss_left = 1; miss_right = 1; tick(); miss_left = 0; miss_right = 0;
        chk("both_miss", {state, score_p1, score_p2}, {3'd3, 4'd1, 4'd0});
        tick();
        miss_left = 1; tick(); miss_left = 0;
        chk("sw_miss_ignored", {state, score_p2}, {3'd1, 4'd0});

        serve_ball();
        miss_left = 1; tick(); miss_left = 0;
        chk("p2_point", 32'(score_p2), 32'd1);
        chk("dir_left", 32'(serve_dir), 32'd0);
        btn_n = 4'h7;
        tick();
        serve_ball();
        miss_left = 1; tick(); miss_left = 0;
        tick();
        chk("game_over", {state, game_over, winner}, {3'd4, 1'b1, 1'b1});
        idle(6);
        chk("held_no_restart", 32'(state), 32'd4);
        btn_n = 4'hF; idle(4);
        chk("armed_wait", 32'(state), 32'd4);
        btn_n = 4'hD; idle(4); btn_n = 4'hF;
        chk("restart", {state, score_p1, score_p2}, {3'd1, 4'd0, 4'd0});

        serve_ball();
        pulse_frame();
        rst = 1; idle(2); rst = 0;
        chk("rst_mid_play", {state, score_p1, score_p2}, {3'd0, 4'd0, 4'd0});
        tick();
        chk("rst_no_pulse", {load_pos, serve, step_en}, 3'd0);

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            frame_start = ($urandom_range(0, 3) == 0);
            miss_left   = ($urandom_range(0, 14) == 0);
            miss_right  = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 7) == 0) btn_n = 4'($urandom());
            tick();
        end
        rst = 0; frame_start = 0; miss_left = 0; miss_right = 0; btn_n = 4'hF;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
